// File: rtl/stdp_ctrl.sv
// STDP learning-rule front end: times pre/post spikes per synapse and serializes
// single-step weight commands (one per cycle, registered) to the weight counter.
module stdp_ctrl #(
   parameter int N_SYN  = 4,
   parameter int AW     = 2,
   parameter int WINDOW = 8,
   parameter int TW     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SYN-1:0] pre_spike,
   input  logic             post_spike,
   input  logic             learn_en,
   output logic             en,
   output logic             incr,
   output logic             decr,
   output logic             sim,
   output logic [AW-1:0]    syn_addr,
   output logic             busy
);

   localparam logic [TW-1:0] LIM   = TW'(WINDOW);
   localparam logic [TW-1:0] STALE = TW'(WINDOW + 1);

   typedef enum logic {S_IDLE, S_ISSUE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [TW-1:0]    r_pre_t [N_SYN];
   logic [TW-1:0]    r_post_t;
   logic [N_SYN-1:0] r_ltp;
   logic [N_SYN-1:0] r_ltd;

   logic [N_SYN-1:0] w_ltp_ev;
   logic [N_SYN-1:0] w_ltd_ev;
   logic [N_SYN-1:0] w_iss_ltp;
   logic [N_SYN-1:0] w_iss_ltd;
   logic [N_SYN-1:0] w_ltp_nxt;
   logic [N_SYN-1:0] w_ltd_nxt;
   logic             w_go;
   logic             w_found;
   logic             w_is_ltp;
   logic [AW-1:0]    w_addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_ltp_ev    = '0;
      w_ltd_ev    = '0;
      w_iss_ltp   = '0;
      w_iss_ltd   = '0;
      w_found     = 1'b0;
      w_is_ltp    = 1'b0;
      w_addr      = '0;
      w_go        = learn_en && (r_state == S_ISSUE);
      w_ltp_nxt   = r_ltp;
      w_ltd_nxt   = r_ltd;
      w_state_nxt = S_IDLE;

      for (int i = 0; i < N_SYN; i++) begin
         w_ltp_ev[i] = learn_en && post_spike && ((r_pre_t[i] <= LIM) || pre_spike[i]);
         w_ltd_ev[i] = learn_en && pre_spike[i] && !post_spike && (r_post_t <= LIM);
      end

      // LTP has priority over LTD; lowest index wins within each kind
      for (int i = 0; i < N_SYN; i++) begin
         if (w_go && !w_found && r_ltp[i]) begin
            w_iss_ltp[i] = 1'b1;
            w_found      = 1'b1;
            w_is_ltp     = 1'b1;
            w_addr       = AW'(i);
         end
      end
      for (int i = 0; i < N_SYN; i++) begin
         if (w_go && !w_found && r_ltd[i]) begin
            w_iss_ltd[i] = 1'b1;
            w_found      = 1'b1;
            w_addr       = AW'(i);
         end
      end

      // An event identical to the one being issued is absorbed by that command;
      // an opposite event cancels the pending one of the other kind.
      for (int i = 0; i < N_SYN; i++) begin
         w_ltp_nxt[i] = r_ltp[i] && !w_iss_ltp[i];
         w_ltd_nxt[i] = r_ltd[i] && !w_iss_ltd[i];
         if (w_ltp_ev[i] && !w_iss_ltp[i]) begin
            if (w_ltd_nxt[i]) w_ltd_nxt[i] = 1'b0;
            else              w_ltp_nxt[i] = 1'b1;
         end
         if (w_ltd_ev[i] && !w_iss_ltd[i]) begin
            if (w_ltp_nxt[i]) w_ltp_nxt[i] = 1'b0;
            else              w_ltd_nxt[i] = 1'b1;
         end
      end

      if (!learn_en) begin
         w_ltp_nxt = '0;
         w_ltd_nxt = '0;
      end

      if (learn_en && ((w_ltp_nxt | w_ltd_nxt) != '0)) begin
         w_state_nxt = S_ISSUE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_SYN; i++) r_pre_t[i] <= STALE;
         r_post_t <= STALE;
         r_ltp    <= '0;
         r_ltd    <= '0;
         en       <= 1'b0;
         incr     <= 1'b0;
         decr     <= 1'b0;
         sim      <= 1'b0;
         syn_addr <= '0;
         busy     <= 1'b0;
      end else begin
         for (int i = 0; i < N_SYN; i++) begin
            if (pre_spike[i])           r_pre_t[i] <= '0;
            else if (r_pre_t[i] <= LIM) r_pre_t[i] <= r_pre_t[i] + 1'b1;
         end
         if (post_spike)            r_post_t <= '0;
         else if (r_post_t <= LIM)  r_post_t <= r_post_t + 1'b1;
         r_ltp <= w_ltp_nxt;
         r_ltd <= w_ltd_nxt;
         en    <= w_found;
         incr  <= w_found && w_is_ltp;
         decr  <= w_found && !w_is_ltp;
         sim   <= learn_en;
         busy  <= (w_ltp_nxt | w_ltd_nxt) != '0;
         if (w_found) syn_addr <= w_addr;
      end
   end

endmodule

// File: tb/tb_stdp_ctrl.sv
// Scoreboard bench for stdp_ctrl: spike-time reference model predicts commands,
// a negedge monitor pops and compares every en strobe plus busy/sim each cycle.
module tb_stdp_ctrl;
   localparam int N_SYN = 4;
   localparam int AW = 2;
   localparam int WINDOW = 8;
   localparam int TW = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N_SYN-1:0] pre_spike = '0;
   logic             post_spike = 1'b0;
   logic             learn_en = 1'b0;
   logic             en, incr, decr, sim, busy;
   logic [AW-1:0]    syn_addr;

   stdp_ctrl #(.N_SYN(N_SYN), .AW(AW), .WINDOW(WINDOW), .TW(TW)) dut (
      .clk(clk), .rst(rst), .pre_spike(pre_spike), .post_spike(post_spike),
      .learn_en(learn_en), .en(en), .incr(incr), .decr(decr), .sim(sim),
      .syn_addr(syn_addr), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {int cyc; int addr; bit inc;} cmd_t;
   cmd_t q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_pre [N_SYN];
   int last_post;
   int net [N_SYN];      // +1 potentiation owed, -1 depression owed, 0 nothing
   bit exp_busy = 0;
   bit exp_sim = 0;

   task automatic model_reset();
      for (int i = 0; i < N_SYN; i++) begin
         last_pre[i] = -1000;
         net[i] = 0;
      end
      last_post = -1000;
      exp_busy = 0;
      exp_sim = 0;
      q.delete();
   endtask

   // one clock edge worth of behaviour, k = index of this edge
   task automatic model_edge(input logic [N_SYN-1:0] pre, input bit post, input bit le);
      int idx;
      int dir;
      int d;
      int k;
      k = cyc;
      idx = -1;
      dir = 0;
      if (!le) begin
         for (int i = 0; i < N_SYN; i++) net[i] = 0;
      end else begin
         for (int i = 0; i < N_SYN; i++) if (idx < 0 && net[i] == 1) begin idx = i; dir = 1; end
         for (int i = 0; i < N_SYN; i++) if (idx < 0 && net[i] == -1) begin idx = i; dir = -1; end
         if (idx >= 0) begin
            q.push_back('{cyc: k, addr: idx, inc: (dir == 1)});
            net[idx] = 0;
         end
         for (int i = 0; i < N_SYN; i++) begin
            d = 0;
            if (post && (pre[i] || (k - last_pre[i] <= WINDOW + 1))) d = 1;
            else if (pre[i] && !post && (k - last_post <= WINDOW + 1)) d = -1;
            if (d != 0 && !(i == idx && d == dir) && net[i] != d) net[i] = net[i] + d;
         end
      end
      for (int i = 0; i < N_SYN; i++) if (pre[i]) last_pre[i] = k;
      if (post) last_post = k;
      exp_busy = 0;
      for (int i = 0; i < N_SYN; i++) if (net[i] != 0) exp_busy = 1;
      exp_sim = le;
      cyc++;
   endtask

   task automatic step(input logic [N_SYN-1:0] pre, input bit post, input bit le);
      pre_spike = pre;
      post_spike = post;
      learn_en = le;
      @(posedge clk);
      model_edge(pre, post, le);
      @(negedge clk);
   endtask

   task automatic idle(input int n, input bit le);
      for (int i = 0; i < n; i++) step('0, 1'b0, le);
   endtask

   task automatic check_zero(input string name);
      checks++;
      if (en !== 1'b0 || incr !== 1'b0 || decr !== 1'b0 || sim !== 1'b0 ||
          busy !== 1'b0 || syn_addr !== '0) begin
         errors++;
         $display("FAIL %s: en=%b incr=%b decr=%b sim=%b busy=%b addr=%0d, required all 0",
                  name, en, incr, decr, sim, busy, syn_addr);
      end
   endtask

   always @(negedge clk) begin
      cmd_t e;
      if (!rst) begin
         if (en) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_cmd: cyc=%0d addr=%0d incr=%b decr=%b, required no command",
                        cyc, syn_addr, incr, decr);
            end else begin
               e = q.pop_front();
               if (e.cyc != cyc - 1 || syn_addr !== AW'(e.addr) || incr !== e.inc || decr !== !e.inc) begin
                  errors++;
                  $display("FAIL cmd: at cyc %0d got addr=%0d incr=%b decr=%b, required edge %0d addr=%0d incr=%b decr=%b",
                           cyc - 1, syn_addr, incr, decr, e.cyc, e.addr, e.inc, !e.inc);
               end
            end
         end else if (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_cmd: no en at edge %0d, required addr=%0d incr=%b", e.cyc, e.addr, e.inc);
         end
         checks++;
         if (busy !== exp_busy) begin
            errors++;
            $display("FAIL busy: cyc=%0d got %b required %b", cyc, busy, exp_busy);
         end
         checks++;
         if (sim !== exp_sim) begin
            errors++;
            $display("FAIL sim: cyc=%0d got %b required %b", cyc, sim, exp_sim);
         end
      end
   end

   initial begin
      logic [N_SYN-1:0] rp;
      model_reset();
      // reset with spikes active
      rst = 1'b1;
      pre_spike = '1;
      post_spike = 1'b1;
      learn_en = 1'b1;
      repeat (3) @(negedge clk);
      check_zero("reset_state");
      rst = 1'b0;

      // post with no prior pre
      step('0, 1'b1, 1'b1);
      idle(4, 1'b1);

      // pre[2] then post 3 cycles later: LTP; pre then post 10 cycles later: none
      idle(12, 1'b1);
      step(4'b0100, 1'b0, 1'b1);
      idle(2, 1'b1);
      step('0, 1'b1, 1'b1);
      idle(14, 1'b1);
      step(4'b0100, 1'b0, 1'b1);
      idle(9, 1'b1);
      step('0, 1'b1, 1'b1);
      idle(14, 1'b1);

      // post then pre[1] 5 later: LTD; same-cycle pre/post on 3: LTP
      step('0, 1'b1, 1'b1);
      idle(4, 1'b1);
      step(4'b0010, 1'b0, 1'b1);
      idle(14, 1'b1);
      step(4'b1000, 1'b1, 1'b1);
      idle(14, 1'b1);

      // burst of four LTPs
      step(4'b1111, 1'b0, 1'b1);
      idle(1, 1'b1);
      step('0, 1'b1, 1'b1);
      idle(14, 1'b1);

      // learn_en low wipes the LTP
      step(4'b0001, 1'b0, 1'b1);
      step('0, 1'b1, 1'b0);
      step('0, 1'b0, 1'b0);
      idle(14, 1'b1);

      // LTD on 0 queued behind LTPs, then cancelled by an LTP on 0
      step(4'b1110, 1'b0, 1'b1);
      step('0, 1'b1, 1'b1);
      step(4'b0001, 1'b0, 1'b1);
      step('0, 1'b1, 1'b1);
      idle(14, 1'b1);

      // reset after the 2nd command of a burst
      step(4'b1111, 1'b0, 1'b1);
      idle(1, 1'b1);
      step('0, 1'b1, 1'b1);
      idle(2, 1'b1);
      #2 rst = 1'b1;
      #1 check_zero("reset_mid_burst");
      model_reset();
      #1 rst = 1'b0;
      idle(12, 1'b1);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         bit le;
         for (int i = 0; i < N_SYN; i++) rp[i] = ($urandom_range(0, 7) == 0);
         le = ((c / 100) % 5 == 4) ? 1'($urandom_range(0, 1)) : 1'b1;
         step(rp, ($urandom_range(0, 5) == 0), le);
      end
      idle(20, 1'b1);

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d commands still expected, required 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/stdp_ctrl.md
Name: stdp_ctrl

Overview:
- Learning-rule front end of the STDP synapse array.
- Watches N_SYN presynaptic spike lines and one postsynaptic spike line, and measures pre/post timing per synapse.
- Issues serialized single-step weight commands (en/incr/decr/sim/syn_addr) to the weight counter that holds synaptic weights: potentiate when pre precedes post within WINDOW cycles, depress when post precedes pre within WINDOW cycles.

Parameters:
N_SYN, 4, number of synapses (pre inputs); must equal 2**AW
AW, 2, syn_addr width
WINDOW, 8, STDP window in cycles (1..2**TW-2)
TW, 4, timer width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
pre_spike  input  N_SYN  one-cycle presynaptic spike pulses, bit i = synapse i
post_spike  input  1  one-cycle postsynaptic spike pulse
learn_en  input  1  learning enable (level)
en  output  1  command valid, one-cycle strobe per weight step
incr  output  1  potentiate step (valid with en)
decr  output  1  depress step (valid with en)
sim  output  1  learning-active level to weight counter
syn_addr  output  AW  target synapse of current command
busy  output  1  any command pending

Behaviour:
- Reset (async, immediate): en=0, incr=0, decr=0, sim=0, syn_addr=0, busy=0, all pending bits 0; all timers = WINDOW+1 (stale).
- Pre timers pre_t[i]:
  - pre_spike[i] -> 0.
  - Otherwise, if pre_t[i] <= WINDOW, increment by 1; saturate at WINDOW+1.
- Post timer post_t: same rule driven by post_spike.
- Timers run regardless of learn_en.
- LTP detection on post_spike (edge k), for each i:
  - Sets ltp_pend[i] if pre_t[i] <= WINDOW or pre_spike[i]=1 in the same cycle (dt=0 counts as LTP).
  - Example: pre at cycle t, post at t+3, WINDOW=8 -> LTP.
- LTD detection on pre_spike[i] with post_spike=0: sets ltd_pend[i] if post_t <= WINDOW.
  - post_t=WINDOW+1 (stale) -> no event.
- Coalescing:
  - A new event of the same kind for i while already pending is dropped; one command is issued.
- Cancellation:
  - A new LTP for i while ltd_pend[i]=1 clears both, and vice versa (net zero step, no command).
- Issue logic (registered outputs, evaluated each edge):
  - If learn_en=1 and any pending: select lowest i with ltp_pend, else lowest i with ltd_pend.
  - Drive en=1, incr=1 or decr=1 (never both), syn_addr=i; clear that pending bit at the same edge.
  - Otherwise en=incr=decr=0 and syn_addr holds its last value.
  - Throughput: one command per cycle.
  - Latency: spike sampled at edge k sets pending; command is visible after edge k+1 if highest priority.
- Same-edge interaction: events detected at an edge merge with pending bits in that edge; the bit cleared by issue is not re-set by a simultaneous identical event (the event is consumed).
- learn_en=0:
  - All pending bits clear at the next edge.
  - No new events are recorded.
  - en/incr/decr=0 from the next edge.
- sim = learn_en delayed one cycle.
- busy = registered OR of all pending bits after the edge update.
- FSM states: IDLE (no pending, en=0) and ISSUE (pending nonempty, one command per cycle).
  - IDLE->ISSUE when pending becomes nonempty with learn_en=1.
  - ISSUE->IDLE when the last pending bit is issued or learn_en=0.
- Reset mid-ISSUE: outputs drop to reset values immediately; pending lost; no partial command.

Test Plan:
- Reset with spikes active -> en=incr=decr=sim=busy=0, syn_addr=0; post_spike with no prior pre -> no command.
- learn_en=1; pre_spike[2] at cycle 0, post_spike at cycle 3 (WINDOW=8) -> exactly one cycle en=1, incr=1, syn_addr=2 after edge 4; pre at 0, post at 10 -> no command.
- post_spike at 0, pre_spike[1] at 5 -> one cycle en=1, decr=1, syn_addr=1; pre and post same cycle on synapse 3 -> incr on addr 3.
- pre_spike=4'b1111 at cycle 0, post at 2 -> four consecutive en cycles, incr, syn_addr 0,1,2,3, busy high until the last is issued.
- Cancellation: pre_spike[0] at 0, post at 1 with learn_en=0 during 1..2 -> nothing issued; with learn_en=1 but post at 1 and another pre_spike[0] at 1 held off by higher-priority traffic -> pending cleared, no command for addr 0.
- Assert rst during a 4-command burst after the 2nd command -> outputs 0 asynchronously; no further en after rst release without new spikes.
